// File: rtl/dice_roll_ctrl_if.sv
// Purpose: bundles the dice roll scheduler's request, dice and result signals.
// Latency: none, wires only.
// Backpressure: none. Requests are level inputs; the scheduler owns every output.
// Ports (master = scheduler side):
//   req[1:0]        in   per-player roll request level
//   dice_value[2:0] in   current face reported by the dice core
//   step            out  advance the dice core by one roll
//   grant[1:0]      out  one-hot owner of the dice
//   busy            out  a roll is in progress
//   result[2:0]     out  latched final face
//   result_player   out  owner of result
//   result_valid    out  result is meaningful
//   score0/score1   out  running totals, present only when DICE_CTRL_TALLY_EN is defined
interface dice_roll_ctrl_if;
  logic [1:0] req;
  logic [2:0] dice_value;
  logic       step;
  logic [1:0] grant;
  logic       busy;
  logic [2:0] result;
  logic       result_player;
  logic       result_valid;
`ifdef DICE_CTRL_TALLY_EN
  logic [7:0] score0;
  logic [7:0] score1;

  modport master (
    input  req, dice_value,
    output step, grant, busy, result, result_player, result_valid, score0, score1
  );
  modport slave (
    output req, dice_value,
    input  step, grant, busy, result, result_player, result_valid, score0, score1
  );
`else
  modport master (
    input  req, dice_value,
    output step, grant, busy, result, result_player, result_valid
  );
  modport slave (
    output req, dice_value,
    input  step, grant, busy, result, result_player, result_valid
  );
`endif
endinterface

// File: rtl/dice_roll_ctrl.sv
// Purpose: two-player roll scheduler; arbitrates requests round-robin and drives the
//          dice core through fast spin, decelerating spin and display hold.
// Latency: req rising edge -> grant/busy two cycles later when idle; busy lasts
//          FAST_CYCLES + 2^(SLOW_STEPS+1) - 2 + HOLD_CYCLES cycles.
// Backpressure: none; requests arriving while busy are remembered (one per player)
//          and served on the first idle cycle.
// Ports: clk (rising edge), rst (synchronous, active high), bus (dice_roll_ctrl_if.master).
// Optional feature: define DICE_CTRL_TALLY_EN to add saturating per-player score totals.
module dice_roll_ctrl #(
  parameter int FAST_CYCLES = 16,  // contiguous step pulses in the fast phase (>= 1)
  parameter int SLOW_STEPS  = 4,   // step pulses in the slow phase (1..6)
  parameter int HOLD_CYCLES = 8    // cycles in the display hold (>= 2)
) (
  input  logic             clk,
  input  logic             rst,
  dice_roll_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FAST = 2'd1,
    SLOW = 2'd2,
    HOLD = 2'd3
  } state_t;

  // One shared down-counter serves all three phases, so size it for the largest span.
  localparam int SLOW_SPAN = 2 ** (SLOW_STEPS + 1);
  localparam int MAX_A     = (FAST_CYCLES > HOLD_CYCLES) ? FAST_CYCLES : HOLD_CYCLES;
  localparam int MAX_C     = (MAX_A > SLOW_SPAN) ? MAX_A : SLOW_SPAN;
  localparam int CNT_W     = $clog2(MAX_C + 1);
  localparam int IDX_W     = 3;

  localparam logic [CNT_W-1:0] FAST_LOAD = CNT_W'(FAST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SLOW_STEPS - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             step_q, step_n;
  logic [1:0]       grant_q, grant_n;
  logic             busy_q, busy_n;
  logic [2:0]       result_q, result_n;
  logic             rplayer_q, rplayer_n;
  logic             rvalid_q, rvalid_n;
  logic [1:0]       pend_q, pend_n, pend_clr, pend_set;
  logic [1:0]       req_d;
  logic             last_q, last_n;
  logic             pick;

`ifdef DICE_CTRL_TALLY_EN
  logic [7:0] score0_q, score0_n;
  logic [7:0] score1_q, score1_n;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {6'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
`endif

  // Only rising edges of a request level register as a new request.
  assign pend_set = bus.req & ~req_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      step_q    <= 1'b0;
      grant_q   <= 2'b00;
      busy_q    <= 1'b0;
      result_q  <= 3'd0;
      rplayer_q <= 1'b0;
      rvalid_q  <= 1'b0;
      pend_q    <= 2'b00;
      req_d     <= 2'b00;
      last_q    <= 1'b1;
`ifdef DICE_CTRL_TALLY_EN
      score0_q  <= 8'd0;
      score1_q  <= 8'd0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      step_q    <= step_n;
      grant_q   <= grant_n;
      busy_q    <= busy_n;
      result_q  <= result_n;
      rplayer_q <= rplayer_n;
      rvalid_q  <= rvalid_n;
      pend_q    <= pend_n;
      req_d     <= bus.req;
      last_q    <= last_n;
`ifdef DICE_CTRL_TALLY_EN
      score0_q  <= score0_n;
      score1_q  <= score1_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    step_n    = 1'b0;
    grant_n   = grant_q;
    busy_n    = busy_q;
    result_n  = result_q;
    rplayer_n = rplayer_q;
    rvalid_n  = rvalid_q;
    pend_clr  = 2'b00;
    last_n    = last_q;
    pick      = 1'b0;
`ifdef DICE_CTRL_TALLY_EN
    score0_n  = score0_q;
    score1_n  = score1_q;
`endif

    unique case (state)
      IDLE: begin
        if (pend_q != 2'b00) begin
          // Both waiting: serve whoever did not roll last. Otherwise the lone requester.
          pick      = (pend_q == 2'b11) ? ~last_q : pend_q[1];
          grant_n   = pick ? 2'b10 : 2'b01;
          pend_clr  = grant_n;
          last_n    = pick;
          busy_n    = 1'b1;
          rvalid_n  = 1'b0;
          // Step is registered, so raising it here makes the first FAST cycle a step.
          step_n    = 1'b1;
          cnt_n     = FAST_LOAD;
          state_n   = FAST;
        end
      end

      FAST: begin
        if (cnt == '0) begin
          // The last fast step is in this cycle; the first slow step is two cycles on,
          // so the interval counter starts at zero.
          cnt_n   = '0;
          idx_n   = '0;
          state_n = SLOW;
        end else begin
          cnt_n  = cnt - CNT_W'(1);
          step_n = 1'b1;
        end
      end

      SLOW: begin
        if (step_q) begin
          if (idx == LAST_IDX) begin
            cnt_n   = HOLD_LOAD;
            state_n = HOLD;
          end else begin
            // Next pulse fires 2^(idx+2) cycles after this one. One cycle is spent
            // counting to zero and one raising the registered step, hence the -2.
            idx_n = idx + IDX_W'(1);
            cnt_n = (CNT_W'(1) << (idx + IDX_W'(2))) - CNT_W'(2);
          end
        end else if (cnt == '0) begin
          step_n = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      HOLD: begin
        // First hold cycle: the dice core has settled after the final step.
        if (cnt == HOLD_LOAD) begin
          result_n  = bus.dice_value;
          rplayer_n = grant_q[1];
          rvalid_n  = 1'b1;
`ifdef DICE_CTRL_TALLY_EN
          if (grant_q[1]) begin
            score1_n = sat_add(score1_q, bus.dice_value);
          end else begin
            score0_n = sat_add(score0_q, bus.dice_value);
          end
`endif
        end
        if (cnt == '0) begin
          grant_n = 2'b00;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // A fresh edge on the same cycle as the grant is kept, so it is not lost.
    pend_n = (pend_q & ~pend_clr) | pend_set;
  end

  assign bus.step          = step_q;
  assign bus.grant         = grant_q;
  assign bus.busy          = busy_q;
  assign bus.result        = result_q;
  assign bus.result_player = rplayer_q;
  assign bus.result_valid  = rvalid_q;
`ifdef DICE_CTRL_TALLY_EN
  assign bus.score0        = score0_q;
  assign bus.score1        = score1_q;
`endif

endmodule

// File: doc/dice_roll_ctrl.md
# dice_roll_ctrl

Two-player roll scheduler for the shared dice core. Arbitrates roll requests from two players, owns the dice core's step input, and sequences each roll as a fast spin, a decelerating spin and a display hold. Latches the final face and the owning player for the display and score logic downstream.

## Interface
- FAST_CYCLES, 16, consecutive Step pulses in the fast phase (≥1)
- SLOW_STEPS, 4, Step pulses in the slow phase; step k (k=0..) fires 2^(k+1) cycles after the previous Step (1..6)
- HOLD_CYCLES, 8, cycles spent in HOLD (≥2)
- Clock  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  2  per-player roll request level; only rising edges count
- DiceValue  in  3  current dice face (1..6); updates on the edge where Step is high
- Step  out  1  advance dice core one roll, one pulse per cycle high
- Grant  out  2  one-hot owner of the dice, 00 when IDLE
- Busy  out  1  high in FAST, SLOW and HOLD
- Result  out  3  latched final face
- ResultPlayer  out  1  player that produced Result
- ResultValid  out  1  Result is valid; cleared on the next grant
- Score0, Score1  out  8 each  running totals; present only with DICE_CTRL_TALLY_EN

## Operation
- Request edge detect: registered ReqD; Pending[i] set when Req[i]=1 and ReqD[i]=0. Set in any state, including while player i owns the dice. Cleared only when player i is granted. Held-high Req gives one request.
- Round robin: LastPlayer reset value 1. If both Pending bits are set in IDLE, grant the player ≠ LastPlayer; otherwise grant the single pending player. LastPlayer updates on every grant.
- FSM states: IDLE, FAST, SLOW, HOLD.
- IDLE → FAST when Pending≠0. Same edge: Grant set, ResultValid cleared, Pending bit cleared, counters loaded.
- FAST: Step=1 every cycle for FAST_CYCLES cycles, then → SLOW.
- SLOW: interval counter. Step pulses after 2, 4, 8, … cycles. After the SLOW_STEPS-th pulse → HOLD on the next edge.
- HOLD, first cycle: Result←DiceValue, ResultPlayer←owner, ResultValid←1. These are visible from the second HOLD cycle.
- HOLD: after HOLD_CYCLES cycles → IDLE, Grant←00. Result, ResultPlayer and ResultValid stay until the next grant.
- DiceValue is not range-checked; it is captured as-is.
- Reset: Step=0, Grant=00, Busy=0, Result=0, ResultPlayer=0, ResultValid=0, Pending=00, ReqD=00, LastPlayer=1, state IDLE, Score0=Score1=0. Reset mid-roll aborts immediately. No capture and no tally occur for the aborted roll.

## Timing
- Req rising edge sampled at edge c → Pending visible c+1 → Grant/Busy high from c+2 (if IDLE).
- Step is registered. With defaults, the first Step is in the first FAST cycle, 16 consecutive pulses follow, then slow pulses at +2, +4, +8, +16 cycles.
- Busy duration: FAST_CYCLES + (2^(SLOW_STEPS+1) − 2) + HOLD_CYCLES cycles. With defaults that is 16+30+8 = 54.
- Back-to-back: a request pending during HOLD is granted on the first IDLE cycle. Busy is low for exactly one cycle between rolls.
- Step never asserts in IDLE or HOLD.

## Configuration
- DICE_CTRL_TALLY_EN defined: Score0/Score1 ports exist. On the Result capture edge, Score[owner] ← min(Score[owner]+DiceValue, 255). The other score is unchanged.
- DICE_CTRL_TALLY_EN undefined: no Score ports and no tally logic. All other behaviour is identical.

## Test plan
- Reset, then a single Req0 pulse → Grant=01 from two cycles later; 20 Step pulses total (16 contiguous, then gaps of 2/4/8/16); Result equals the dice model face after the last Step; ResultPlayer=0; ResultValid=1; Busy high for 54 cycles.
- Req rising on both bits on the same edge after reset → player 0 is served first, then player 1 one IDLE cycle after the first HOLD ends; ResultPlayer goes 0 then 1.
- During player 0's roll, pulse Req0, then Req1 → next grant is player 1, then player 0; three rolls total.
- Reset asserted during SLOW → next cycle Step=0, Grant=00, Busy=0, Result=0, ResultValid=0; no grant follows without a new Req edge.
- Req0 held high for 200 cycles → exactly one roll.
- With DICE_CTRL_TALLY_EN and the dice model fixed at 6: 42 rolls by player 0 give Score0=252; the 43rd gives 255 and further rolls hold 255; Score1 stays 0.
